// File: rtl/bw_r_l2d_param.sv
// Parametrised L2 data sub-bank: NUM_WAYS x 2**SET_W lines of NUM_WORDS*WORD_W bits, two-cycle
// read hold wired-OR onto decc, busy flag, eFuse redundancy chain. Optional macro: L2D_WR_BYPASS_EN.
module bw_r_l2d_param #(
  parameter int NUM_WAYS  = 2,
  parameter int SET_W     = 10,
  parameter int NUM_WORDS = 4,
  parameter int WORD_W    = 39,
  parameter int NUM_RED   = 6,
  parameter int RED_W     = 9,
  localparam int LINE_W   = NUM_WORDS * WORD_W,
  localparam int RID_W    = (NUM_RED > 1) ? $clog2(NUM_RED) : 1,
  localparam int DEPTH    = 2 ** SET_W
) (
  input  logic                 rclk,
  input  logic                 arst_l,
  input  logic                 acc_l,
  input  logic                 wr_en_l,
  input  logic [NUM_WAYS-1:0]  way_sel_l,
  input  logic [SET_W-1:0]     set_l,
  input  logic [NUM_WORDS-1:0] word_en_l,
  input  logic [LINE_W-1:0]    decc_in_l,
  input  logic [LINE_W-1:0]    decc_read_in,
  input  logic                 mem_write_disable,
  input  logic                 sehold,
  output logic [LINE_W-1:0]    decc_out,
  output logic                 busy,
  input  logic                 fuse_wren,
  input  logic                 fuse_rden,
  input  logic [RID_W-1:0]     fuse_rid,
  input  logic                 fuse_data_in,
  input  logic                 fuse_read_data_in,
  output logic                 fuse_data_out
);

  typedef enum logic [1:0] {
    OUT_IDLE   = 2'd0,
    OUT_HOLD_A = 2'd1,
    OUT_HOLD_B = 2'd2
  } out_state_t;

  // Request handshake: a request is accepted in the cycle where acc_l is low, at least one way is
  // selected, and the bank is neither busy, write-disabled nor held by sehold. The accepted request
  // is captured at that edge; busy is high for exactly the following cycle, during which the array
  // is accessed and any new request is dropped, so accepts are spaced at least two cycles apart.
  logic                 accept;
  logic                 busy_q;
  logic                 wr_q;
  logic [NUM_WAYS-1:0]  way_q;
  logic [SET_W-1:0]     set_q;
  logic [NUM_WORDS-1:0] word_en_q;
  logic [LINE_W-1:0]    data_q;

  logic [LINE_W-1:0]    mem [NUM_WAYS][DEPTH];
  logic [LINE_W-1:0]    mask;
  logic [LINE_W-1:0]    rd_line;
  logic [LINE_W-1:0]    wr_line;

  out_state_t           out_state;
  out_state_t           out_next;
  logic [LINE_W-1:0]    out_q;
  logic [LINE_W-1:0]    out_d;

  logic [RED_W-1:0]     red_reg  [NUM_RED];
  logic [RED_W-1:0]     red_next [NUM_RED];

  assign accept = ~acc_l & (|(~way_sel_l)) & ~busy_q & ~mem_write_disable & ~sehold;
  assign busy   = busy_q;

  // Request registers only load on accept, so sehold (which blocks accept) holds them as well.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      busy_q    <= 1'b0;
      wr_q      <= 1'b0;
      way_q     <= '0;
      set_q     <= '0;
      word_en_q <= '0;
      data_q    <= '0;
    end else begin
      busy_q <= accept;
      if (accept) begin
        wr_q      <= ~wr_en_l;
        way_q     <= ~way_sel_l;
        set_q     <= ~set_l;
        word_en_q <= ~word_en_l;
        data_q    <= ~decc_in_l;
      end
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      mask[i*WORD_W +: WORD_W] = {WORD_W{word_en_q[i]}};
    end
  end

  // Scan from the top way down so the lowest selected way wins.
  always_comb begin
    rd_line = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (way_q[w]) begin
        rd_line = mem[w][set_q];
      end
    end
  end

`ifdef L2D_WR_BYPASS_EN
  assign wr_line = (data_q & mask) | (rd_line & ~mask);
`else
  assign wr_line = '0;
`endif

  // Array is not reset; an async reset clears busy_q and so aborts a pending write.
  always_ff @(posedge rclk) begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (busy_q && wr_q && way_q[w]) begin
        mem[w][set_q] <= (data_q & mask) | (mem[w][set_q] & ~mask);
      end
    end
  end

  // Output hold: loaded at the end of the busy cycle, shown for two cycles, then cleared.
  always_comb begin
    out_next = out_state;
    out_d    = out_q;
    if (busy_q) begin
      out_next = OUT_HOLD_A;
      out_d    = wr_q ? wr_line : rd_line;
    end else begin
      case (out_state)
        OUT_HOLD_A: out_next = OUT_HOLD_B;
        OUT_HOLD_B: begin
          out_next = OUT_IDLE;
          out_d    = '0;
        end
        default: begin
          out_next = OUT_IDLE;
          out_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      out_state <= OUT_IDLE;
      out_q     <= '0;
    end else begin
      out_state <= out_next;
      out_q     <= out_d;
    end
  end

  assign decc_out = (out_state == OUT_IDLE) ? decc_read_in : (out_q | decc_read_in);

  // Fuse chain: a targeted write shift beats a whole-chain read shift; an out-of-range rid does nothing.
  always_comb begin
    for (int i = 0; i < NUM_RED; i++) begin
      red_next[i] = red_reg[i];
    end
    if (fuse_wren) begin
      for (int i = 0; i < NUM_RED; i++) begin
        if (fuse_rid == RID_W'(i)) begin
          red_next[i] = {red_reg[i][RED_W-2:0], fuse_data_in};
        end
      end
    end else if (fuse_rden) begin
      red_next[0] = {red_reg[0][RED_W-2:0], fuse_read_data_in};
      for (int i = 1; i < NUM_RED; i++) begin
        red_next[i] = {red_reg[i][RED_W-2:0], red_reg[i-1][RED_W-1]};
      end
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      for (int i = 0; i < NUM_RED; i++) begin
        red_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RED; i++) begin
        red_reg[i] <= red_next[i];
      end
    end
  end

  assign fuse_data_out = red_reg[NUM_RED-1][RED_W-1];

endmodule

// File: tb/tb_bw_r_l2d_param.sv
// Self-checking bench for bw_r_l2d_param: directed scenarios plus a randomized access stream
// checked against a line-level array model and a per-cycle expected-output schedule.
module tb_bw_r_l2d_param;
  localparam int NUM_WAYS  = 2;
  localparam int SET_W     = 10;
  localparam int NUM_WORDS = 4;
  localparam int WORD_W    = 39;
  localparam int NUM_RED   = 6;
  localparam int RED_W     = 9;
  localparam int LINE_W    = NUM_WORDS * WORD_W;
  localparam int RID_W     = 3;
  localparam int DEPTH     = 2 ** SET_W;
  localparam int CHAIN_W   = NUM_RED * RED_W;
`ifdef L2D_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic                 rclk = 1'b0;
  logic                 arst_l;
  logic                 acc_l, wr_en_l, mem_write_disable, sehold;
  logic [NUM_WAYS-1:0]  way_sel_l;
  logic [SET_W-1:0]     set_l;
  logic [NUM_WORDS-1:0] word_en_l;
  logic [LINE_W-1:0]    decc_in_l, decc_read_in, decc_out;
  logic                 busy;
  logic                 fuse_wren, fuse_rden, fuse_data_in, fuse_read_data_in, fuse_data_out;
  logic [RID_W-1:0]     fuse_rid;

  always #5 rclk = ~rclk;

  bw_r_l2d_param #(
    .NUM_WAYS(NUM_WAYS), .SET_W(SET_W), .NUM_WORDS(NUM_WORDS),
    .WORD_W(WORD_W), .NUM_RED(NUM_RED), .RED_W(RED_W)
  ) dut (
    .rclk(rclk), .arst_l(arst_l), .acc_l(acc_l), .wr_en_l(wr_en_l),
    .way_sel_l(way_sel_l), .set_l(set_l), .word_en_l(word_en_l),
    .decc_in_l(decc_in_l), .decc_read_in(decc_read_in),
    .mem_write_disable(mem_write_disable), .sehold(sehold),
    .decc_out(decc_out), .busy(busy),
    .fuse_wren(fuse_wren), .fuse_rden(fuse_rden), .fuse_rid(fuse_rid),
    .fuse_data_in(fuse_data_in), .fuse_read_data_in(fuse_read_data_in),
    .fuse_data_out(fuse_data_out)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [LINE_W-1:0]  model_mem [int];
  logic [LINE_W-1:0]  exp_sched [int];
  logic [CHAIN_W-1:0] m_chain;
  logic [LINE_W-1:0]  line_a;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v = '0;
    for (int k = 0; k < (LINE_W + 31) / 32; k++) v = (v << 32) | LINE_W'($urandom);
    return v;
  endfunction

  function automatic logic [LINE_W-1:0] word_mask(input logic [NUM_WORDS-1:0] we);
    logic [LINE_W-1:0] m = '0;
    for (int k = 0; k < NUM_WORDS; k++) if (we[k]) m[k*WORD_W +: WORD_W] = '1;
    return m;
  endfunction

  function automatic logic [LINE_W-1:0] exp_out();
    return exp_sched.exists(cyc) ? exp_sched[cyc] : '0;
  endfunction

  task automatic step();
    @(posedge rclk);
    #2;
    cyc++;
  endtask

  task automatic idle_inputs();
    acc_l = 1'b1; wr_en_l = 1'b1; way_sel_l = '1; set_l = '1; word_en_l = '1;
    decc_in_l = '1; decc_read_in = '0; mem_write_disable = 1'b0; sehold = 1'b0;
    fuse_wren = 1'b0; fuse_rden = 1'b0; fuse_rid = '0; fuse_data_in = 1'b0;
    fuse_read_data_in = 1'b0;
  endtask

  task automatic drive_req(input logic wr, input logic [NUM_WAYS-1:0] ways, input int set,
                           input logic [NUM_WORDS-1:0] we, input logic [LINE_W-1:0] data);
    acc_l = 1'b0; wr_en_l = ~wr; way_sel_l = ~ways; set_l = ~SET_W'(set);
    word_en_l = ~we; decc_in_l = ~data;
  endtask

  // Accepted access in the current cycle: update the array model and schedule what decc shows.
  task automatic model_access(input logic wr, input logic [NUM_WAYS-1:0] ways, input int set,
                              input logic [NUM_WORDS-1:0] we, input logic [LINE_W-1:0] data);
    logic [LINE_W-1:0] mk, old_v, new_v, shown;
    bit first;
    int k;
    first = 1'b1;
    shown = '0;
    mk = word_mask(we);
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (ways[w]) begin
        k = w * DEPTH + set;
        old_v = model_mem.exists(k) ? model_mem[k] : 'x;
        new_v = (data & mk) | (old_v & ~mk);
        if (first) begin
          shown = wr ? (BYPASS ? new_v : '0) : old_v;
          first = 1'b0;
        end
        if (wr) model_mem[k] = new_v;
      end
    end
    exp_sched[cyc + 2] = shown;
    exp_sched[cyc + 3] = shown;
  endtask

  // Drives one accepted request; returns in the busy cycle with inputs idle.
  task automatic run_access(input logic wr, input logic [NUM_WAYS-1:0] ways, input int set,
                            input logic [NUM_WORDS-1:0] we, input logic [LINE_W-1:0] data);
    drive_req(wr, ways, set, we, data);
    model_access(wr, ways, set, we, data);
    step();
    idle_inputs();
    #1;
  endtask

  task automatic write_line(input logic [NUM_WAYS-1:0] ways, input int set,
                            input logic [NUM_WORDS-1:0] we, input logic [LINE_W-1:0] data);
    run_access(1'b1, ways, set, we, data);
    step();
  endtask

  task automatic read_line(input logic [NUM_WAYS-1:0] ways, input int set,
                           output logic [LINE_W-1:0] data);
    run_access(1'b0, ways, set, '0, '0);
    step();
    #1;
    data = decc_out;
    step();
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [LINE_W-1:0] rin;
    arst_l = 1'b0;
    idle_inputs();
    rin = rand_line();
    decc_read_in = rin;
    drive_req(1'b0, 2'b01, 10'h3FF, 4'hF, '0);
    m_chain = '0;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (decc_out !== rin) begin errors++; $display("FAIL reset_decc: got %h expected %h", decc_out, rin); end
    checks++; if (fuse_data_out !== 1'b0) begin errors++; $display("FAIL reset_fuse: got %b expected 0", fuse_data_out); end
    step(); step(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_held: got %b expected 0", busy); end
    arst_l = 1'b1;
    idle_inputs();
    exp_sched.delete();
    step();
  endtask

  task automatic test_fuse();
    logic [RED_W-1:0]   pat;
    logic [CHAIN_W-1:0] serial, exp_chain;
    logic               b;
    pat = 9'h1A5;
    for (int i = RED_W - 1; i >= 0; i--) begin
      fuse_wren = 1'b1; fuse_rid = 3'd2; fuse_data_in = pat[i];
      fuse_rden = 1'($urandom_range(0, 1)); fuse_read_data_in = 1'($urandom_range(0, 1));
      m_chain[2*RED_W +: RED_W] = {m_chain[2*RED_W +: RED_W-1], pat[i]};
      step();
    end
    for (int i = 0; i < RED_W; i++) begin
      fuse_wren = 1'b1; fuse_rid = 3'd7; fuse_data_in = 1'($urandom_range(0, 1)); fuse_rden = 1'b0;
      step();
    end
    fuse_wren = 1'b0;
    serial = '0;
    for (int i = 0; i < CHAIN_W; i++) begin
      #1;
      checks++;
      if (fuse_data_out !== m_chain[CHAIN_W-1]) begin
        errors++; $display("FAIL fuse_serial[%0d]: got %b expected %b", i, fuse_data_out, m_chain[CHAIN_W-1]);
      end
      serial = {serial[CHAIN_W-2:0], fuse_data_out};
      b = 1'($urandom_range(0, 1));
      fuse_rden = 1'b1; fuse_read_data_in = b;
      m_chain = {m_chain[CHAIN_W-2:0], b};
      step();
    end
    exp_chain = '0;
    exp_chain[2*RED_W +: RED_W] = 9'h1A5;
    checks++; if (serial !== exp_chain) begin errors++; $display("FAIL fuse_chain_image: got %h expected %h", serial, exp_chain); end
    // Simultaneous write and read shift: only the targeted register moves.
    for (int i = 0; i < 4; i++) begin
      b = 1'($urandom_range(0, 1));
      fuse_wren = 1'b1; fuse_rden = 1'b1; fuse_rid = 3'd0; fuse_data_in = b;
      fuse_read_data_in = 1'($urandom_range(0, 1));
      m_chain[0 +: RED_W] = {m_chain[0 +: RED_W-1], b};
      step();
    end
    fuse_wren = 1'b0;
    for (int i = 0; i < CHAIN_W; i++) begin
      #1;
      checks++;
      if (fuse_data_out !== m_chain[CHAIN_W-1]) begin
        errors++; $display("FAIL fuse_prio_serial[%0d]: got %b expected %b", i, fuse_data_out, m_chain[CHAIN_W-1]);
      end
      b = 1'($urandom_range(0, 1));
      fuse_rden = 1'b1; fuse_read_data_in = b;
      m_chain = {m_chain[CHAIN_W-2:0], b};
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_write_read();
    logic [LINE_W-1:0] exp_w;
    line_a = rand_line();
    exp_w = BYPASS ? line_a : '0;
    run_access(1'b1, 2'b10, 5, 4'hF, line_a);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b expected 1", busy); end
    step(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_clear: got %b expected 0", busy); end
    checks++; if (decc_out !== exp_w) begin errors++; $display("FAIL wr_out_t2: got %h expected %h", decc_out, exp_w); end
    run_access(1'b0, 2'b10, 5, 4'hF, '0);
    checks++; if (decc_out !== exp_w) begin errors++; $display("FAIL wr_out_t3: got %h expected %h", decc_out, exp_w); end
    step(); #1;
    checks++; if (decc_out !== line_a) begin errors++; $display("FAIL raw_t4: got %h expected %h", decc_out, line_a); end
    step(); #1;
    checks++; if (decc_out !== line_a) begin errors++; $display("FAIL raw_t5: got %h expected %h", decc_out, line_a); end
    step(); #1;
    checks++; if (decc_out !== '0) begin errors++; $display("FAIL raw_t6_clear: got %h expected 0", decc_out); end
  endtask

  task automatic test_partial_write();
    logic [LINE_W-1:0] b_line, d_line, e_line, got, exp;
    b_line = rand_line();
    write_line(2'b10, 5, 4'b0100, b_line);
    read_line(2'b10, 5, got);
    exp = line_a;
    exp[2*WORD_W +: WORD_W] = b_line[2*WORD_W +: WORD_W];
    checks++; if (got !== exp) begin errors++; $display("FAIL partial_word2: got %h expected %h", got, exp); end
    write_line(2'b10, 5, 4'b0000, rand_line());
    read_line(2'b10, 5, got);
    checks++; if (got !== exp) begin errors++; $display("FAIL no_word_en: got %h expected %h", got, exp); end
    d_line = rand_line();
    write_line(2'b11, 9, 4'hF, d_line);
    read_line(2'b01, 9, got);
    checks++; if (got !== d_line) begin errors++; $display("FAIL multihot_way0: got %h expected %h", got, d_line); end
    read_line(2'b10, 9, got);
    checks++; if (got !== d_line) begin errors++; $display("FAIL multihot_way1: got %h expected %h", got, d_line); end
    e_line = rand_line();
    write_line(2'b01, 9, 4'hF, e_line);
    read_line(2'b11, 9, got);
    checks++; if (got !== e_line) begin errors++; $display("FAIL lowest_way: got %h expected %h", got, e_line); end
  endtask

  task automatic test_blocked();
    logic [LINE_W-1:0] c_line, d_line, got;
    c_line = rand_line();
    d_line = rand_line();
    write_line(2'b01, 20, 4'hF, c_line);
    run_access(1'b1, 2'b01, 21, 4'hF, d_line);
    drive_req(1'b1, 2'b01, 20, 4'hF, rand_line());
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_cycle_busy: got %b expected 1", busy); end
    step(); idle_inputs(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_cycle_ignored: got %b expected 0", busy); end
    step(); step();
    drive_req(1'b1, 2'b01, 20, 4'hF, rand_line());
    mem_write_disable = 1'b1;
    step(); idle_inputs(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mwd_busy: got %b expected 0", busy); end
    checks++; if (decc_out !== '0) begin errors++; $display("FAIL mwd_decc: got %h expected 0", decc_out); end
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, 2'b01, 20, 4'hF, '0);
      sehold = 1'b1;
      step(); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sehold_busy[%0d]: got %b expected 0", i, busy); end
    end
    idle_inputs();
    step();
    read_line(2'b01, 20, got);
    checks++; if (got !== c_line) begin errors++; $display("FAIL blocked_set20: got %h expected %h", got, c_line); end
    read_line(2'b01, 21, got);
    checks++; if (got !== d_line) begin errors++; $display("FAIL accepted_set21: got %h expected %h", got, d_line); end
  endtask

  task automatic test_wired_or();
    write_line(2'b01, 30, 4'hF, LINE_W'(2));
    run_access(1'b0, 2'b01, 30, 4'hF, '0);
    step();
    decc_read_in = LINE_W'(1);
    #1;
    checks++; if (decc_out !== LINE_W'(3)) begin errors++; $display("FAIL wor_t2: got %h expected 3", decc_out); end
    step(); #1;
    checks++; if (decc_out !== LINE_W'(3)) begin errors++; $display("FAIL wor_t3: got %h expected 3", decc_out); end
    step(); #1;
    checks++; if (decc_out !== LINE_W'(1)) begin errors++; $display("FAIL wor_t4_passthru: got %h expected 1", decc_out); end
    decc_read_in = '0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [LINE_W-1:0] a_line, b_line;
    a_line = rand_line();
    b_line = rand_line();
    write_line(2'b01, 40, 4'hF, a_line);
    write_line(2'b10, 41, 4'hF, b_line);
    step(); step();
    run_access(1'b0, 2'b01, 40, 4'hF, '0);
    step(); #1;
    checks++; if (decc_out !== a_line) begin errors++; $display("FAIL b2b_t2: got %h expected %h", decc_out, a_line); end
    run_access(1'b0, 2'b10, 41, 4'hF, '0);
    checks++; if (decc_out !== a_line) begin errors++; $display("FAIL b2b_t3: got %h expected %h", decc_out, a_line); end
    step(); #1;
    checks++; if (decc_out !== b_line) begin errors++; $display("FAIL b2b_t4: got %h expected %h", decc_out, b_line); end
    step(); #1;
    checks++; if (decc_out !== b_line) begin errors++; $display("FAIL b2b_t5: got %h expected %h", decc_out, b_line); end
    step(); #1;
    checks++; if (decc_out !== '0) begin errors++; $display("FAIL b2b_t6: got %h expected 0", decc_out); end
  endtask

  task automatic test_reset_abort();
    logic [LINE_W-1:0] a_line, got, rin;
    a_line = rand_line();
    write_line(2'b01, 10'h3FF, 4'hF, a_line);
    step(); step();
    drive_req(1'b1, 2'b01, 10'h3FF, 4'hF, rand_line());
    step(); idle_inputs(); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b expected 1", busy); end
    arst_l = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_async_busy: got %b expected 0", busy); end
    step();
    arst_l = 1'b1;
    exp_sched.delete();
    m_chain = '0;
    step();
    read_line(2'b01, 10'h3FF, got);
    checks++; if (got !== a_line) begin errors++; $display("FAIL abort_no_write: got %h expected %h", got, a_line); end
    run_access(1'b0, 2'b01, 10'h3FF, 4'hF, '0);
    step();
    rin = rand_line();
    decc_read_in = rin;
    #1;
    checks++; if (decc_out !== (a_line | rin)) begin errors++; $display("FAIL hold_before_rst: got %h expected %h", decc_out, a_line | rin); end
    arst_l = 1'b0;
    #1;
    checks++; if (decc_out !== rin) begin errors++; $display("FAIL hold_during_rst: got %h expected %h", decc_out, rin); end
    step();
    arst_l = 1'b1;
    idle_inputs();
    exp_sched.delete();
    step();
  endtask

  task automatic test_random();
    logic                 acc, wr, mwd, sh, ok, m_busy;
    logic [NUM_WAYS-1:0]  ways;
    logic [NUM_WORDS-1:0] we;
    logic [LINE_W-1:0]    data, rin;
    int                   set;
    for (int w = 0; w < NUM_WAYS; w++)
      for (int s = 0; s < 8; s++) write_line(NUM_WAYS'(1 << w), s, 4'hF, rand_line());
    step(); step();
    m_busy = 1'b0;
    for (int i = 0; i < 400; i++) begin
      acc  = ($urandom_range(0, 3) != 0);
      ways = NUM_WAYS'($urandom_range(0, 3));
      wr   = 1'($urandom_range(0, 1));
      set  = $urandom_range(0, 7);
      we   = NUM_WORDS'($urandom_range(0, 15));
      data = rand_line();
      mwd  = ($urandom_range(0, 7) == 0);
      sh   = ($urandom_range(0, 7) == 0);
      rin  = ($urandom_range(0, 3) == 0) ? rand_line() : '0;
      drive_req(wr, ways, set, we, data);
      acc_l = ~acc;
      mem_write_disable = mwd;
      sehold = sh;
      decc_read_in = rin;
      #1;
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy[%0d]: got %b expected %b", i, busy, m_busy); end
      checks++;
      if (decc_out !== (exp_out() | rin)) begin
        errors++; $display("FAIL rnd_decc[%0d]: got %h expected %h", i, decc_out, exp_out() | rin);
      end
      ok = acc && (ways != '0) && !m_busy && !mwd && !sh;
      if (ok) model_access(wr, ways, set, we, data);
      m_busy = ok;
      step();
    end
    idle_inputs();
    step();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    idle_inputs();
    arst_l = 1'b0;
    test_reset();
    test_fuse();
    test_write_read();
    test_partial_write();
    test_blocked();
    test_wired_or();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bw_r_l2d_param.md
Name: bw_r_l2d_param

Overview:
Parametrised L2 data sub-bank, the successor to the fixed 2-way/1024-set/156-bit array. Generalised in way count, set depth, word count and word width, with a registered two-cycle read hold, a busy indication and a single-clock eFuse redundancy chain. It sits in the scdata bank and wired-ORs its read data onto the shared decc bus with adjacent sub-banks.

Parameters:
NUM_WAYS, 2, ways per sub-bank (1..16)
SET_W, 10, set index width (depth = 2**SET_W)
NUM_WORDS, 4, word-enable granules per line
WORD_W, 39, bits per granule (data+ECC)
NUM_RED, 6, redundancy registers
RED_W, 9, bits per redundancy register

Ports:
rclk  in  1  clock
arst_l  in  1  async active-low reset
acc_l  in  1  access request (col_offset), active low
wr_en_l  in  1  write, active low; else read
way_sel_l  in  NUM_WAYS  way select, active low
set_l  in  SET_W  set index, active low
word_en_l  in  NUM_WORDS  word enables, active low
decc_in_l  in  NUM_WORDS*WORD_W  write data, active low
decc_read_in  in  NUM_WORDS*WORD_W  upstream read bus (wired-OR input)
mem_write_disable  in  1  blocks new accesses
sehold  in  1  hold captured request registers
decc_out  out  NUM_WORDS*WORD_W  read bus output
busy  out  1  cycle following an accepted access
fuse_wren  in  1  shift one redundancy register
fuse_rden  in  1  shift whole chain
fuse_rid  in  clog2(NUM_RED)  register select for fuse_wren
fuse_data_in  in  1  serial data for fuse_wren
fuse_read_data_in  in  1  chain serial input for fuse_rden
fuse_data_out  out  1  MSB of red_reg[NUM_RED-1]

Behaviour:
- Reset (arst_l=0, async): all pipeline regs, busy, hold regs and red_reg[*] = 0; decc_out = decc_read_in. Array contents are not reset. Reset mid-access aborts the access with no array write.
- Accept in cycle T: ~acc_l & |~way_sel_l & ~busy & ~mem_write_disable. Inputs are inverted and captured into d1 regs at the T edge. sehold=1 holds d1 regs and blocks acceptance.
- busy=1 in cycle T+1. A request in T+1 is ignored: no capture, no effect.
- Cycle T+1, write: for each selected way, line[set] = (data & word mask) | (old & ~mask), where mask is each word_en bit replicated WORD_W times. Multi-hot writes update all selected ways; word_en=0 writes leave the line unchanged. Own output stays 0 (store data is not reflected).
- Cycle T+1, read: the lowest-index selected way is read into the out register.
- decc_out = out_q | decc_read_in in T+2 and T+3, then out_q clears to 0. Outside these cycles decc_out = decc_read_in.
- Back-to-back accepts occur every 2 cycles; a read at T+2 overlapping the hold from the T read: the new data replaces the old at T+4.
- Read-after-write to the same set (write accepted T, read accepted T+2) returns the merged data.
- Fuse chain (on rclk):
  - fuse_wren: red_reg[fuse_rid] = {red_reg[fuse_rid][RED_W-2:0], fuse_data_in}. rid >= NUM_RED: no effect.
  - else fuse_rden: all registers shift as one NUM_RED*RED_W chain, fuse_read_data_in into reg0 LSB, each reg MSB into the next reg LSB.
  - fuse_wren has priority over fuse_rden.
  - Fuse logic is independent of the access pipeline.

Optional Feature:
L2D_WR_BYPASS_EN: when defined, a write also loads the merged line into out_q, so it appears on decc_out at T+2/T+3 like a read. When undefined, writes produce 0 on decc_out (physical behaviour).

Test Plan:
- Reset, then read way0 set 0x3FF -> decc_out = decc_read_in, busy=0; array holds X/prior data only.
- Write way1 set 5, all word_en, data pattern A; read way1 set 5 at T+2 -> decc_out = A at T+4 and T+5, then 0.
- Write word_en=4'b0100 with data B over A -> read returns A with bits[116:78] = B[116:78].
- Request in busy cycle and with mem_write_disable=1 -> no array change, busy unchanged, decc_out 0.
- Read with decc_read_in=0x1 and out data 0x2 -> decc_out = 0x3; sehold held over 3 cycles -> no new accept.
- fuse_wren rid=2 with 9 bits 0x1A5, then 54 fuse_rden shifts -> fuse_data_out serialises the chain, with 0x1A5 in reg2's bit positions; rid=7 -> no change.
